// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Frame timing constants describe the uart_top frame the arbiter waits on.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } arb_state_e;

  localparam int CLKS_PER_BIT       = 1042;
  // start + 8 data + 4 CRC + stop
  localparam int FRAME_BITS         = 14;
  localparam int DEF_TIMEOUT_CYCLES = 16384;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
// Also intended for reuse on the RX side.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    int c;
    valid = 1'b0;
    index = '0;
    c     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(last) + k) % NUM_REQ;
      if (req[c]) begin
        valid = 1'b1;
        index = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_top transmitter among NUM_REQ producers.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        uart_tx_start,
  output logic [DATA_W-1:0]           uart_data_in,
  input  logic                        uart_tx_done,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  logic [NUM_REQ-1:0][DATA_W-1:0] req_bytes;
  assign req_bytes = req_data;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q;
  logic               done_edge;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Edge detect lets uart_tx_done be either a pulse or a held level.
  assign done_edge = uart_tx_done & ~done_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             wd_hit;

  assign wd_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    data_d   = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d = pick_idx;
          data_d   = req_bytes[pick_idx];
          state_d  = START;
        end
      end
      START: begin
        state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      WAIT_DONE: begin
        if (done_edge) begin
          state_d = ACK;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (wd_hit) begin
          state_d = ACK;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      ACK: begin
        last_d  = gnt_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      data_q   <= data_d;
      done_q   <= uart_tx_done;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_err = (state_q == ACK) & to_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Outputs decode straight from registered state so reset clears them at once.
  assign uart_tx_start = (state_q == START);
  assign busy          = (state_q != IDLE);
  assign gnt_id        = gnt_id_q;
  assign uart_data_in  = data_q;
  assign ack           = (state_q == ACK) ? (NUM_REQ'(1) << gnt_id_q) : '0;

endmodule
